przesuniecie_unit: RTL and testbench
====================================

// Module: przesuniecie_unit
// PURPOSE
//  Registered arithmetic left shift of a signed operand, one op of the arithmetic unit.
//  Result = A <<< N; N is the bitwise complement of operand B (B = ~N).
//  Flags report an invalid shift count (error) and lost significant bits (overflow).
//  Inputs are sampled every clock; outputs are valid one cycle later.
// PARAMETERS
//  BITS  32  operand and result width, >= 2
// PORTS
//  i_clk       in   1     clock, rising edge
//  i_rst_n     in   1     asynchronous, active-low reset
//  i_arg_A     in   BITS  operand A, signed two's complement
//  i_arg_B     in   BITS  shift code; shift count N = ~i_arg_B
//  o_result    out  BITS  shifted A, registered
//  o_error     out  1     invalid shift code, registered
//  o_overflow  out  1     significant bits lost, registered
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low.
//  - Reset: o_result = 0, o_error = 0, o_overflow = 0, held while i_rst_n = 0.
//  - Latency 1: outputs update on every rising i_clk from the inputs sampled at that edge.
//    No handshake and no enable.
//  - N = ~i_arg_B, interpreted as a signed BITS-bit value.
//  - Error (N < 0, i.e. i_arg_B[BITS-1] = 0):
//    o_error = 1, o_overflow = 0, o_result = 0.
//  - 0 <= N < BITS:
//    o_result = A << N, zero fill from the right; sign is not preserved.
//    o_overflow = 1 iff A[BITS-1 -: N+1] is not all-0 and not all-1.
//    Equivalent: (result >>> N) != A.
//  - N == BITS (maximum shift):
//    o_result = 0; o_overflow = (A != 0).
//  - N > BITS:
//    o_result = 0, o_overflow = 1 regardless of A.
//  - o_error and o_overflow are never both 1.
//  - N = 0 (i_arg_B = all ones): o_result = A, flags 0.
//  - Combinational path: out-of-range decode, then log2(BITS)-stage barrel shift,
//    then overflow detect, then the output register.
// STRUCTURE
//  - Shared package przesuniecie_pkg:
//    default BITS;
//    localparam SHW = $clog2(BITS)+1;
//    function for the shift-count decode (N from i_arg_B).
//  - One sub-module: przesuniecie_barrel. It is combinational:
//    in: A and N[SHW-1:0]; out: shifted value and lost-bits flag.
//  - Top level holds the range/error decode and the output flops.
// TESTING (BITS = 32; check outputs one clock after driving inputs)
//  1 Reset mid-run: assert i_rst_n = 0 asynchronously.
//    -> all outputs 0 immediately, before the next clock edge.
//  2 A = 0x00000003, B = ~5 -> result 0x00000060, error 0, overflow 0.
//    A = 0x12345678, B = 32'hFFFFFFFF (N = 0) -> result 0x12345678, flags 0.
//  3 A = 0x40000000, B = ~1 -> result 0x80000000, overflow 1.
//    A = 0xC0000000, B = ~1 -> result 0x80000000, overflow 0.
//  4 N = 32 (B = ~32):
//    A = 0x00000000 -> result 0, overflow 0;
//    A = 0x80000000 -> result 0, overflow 1;
//    A = 0x00000001 -> result 0, overflow 1.
//  5 N > 32, random N in 33..2^31-1, any A including 0 and 0x80000000
//    -> result 0, overflow 1, error 0.
//    B = 0x00000005 (MSB 0, so N < 0) -> error 1, overflow 0, result 0.
//  6 Random sweep: random A, N in 0..31.
//    -> compare every cycle against the behavioural model:
//       ((A << N) result; (A << N) >>> N != A as overflow).

Source files
------------

// File: rtl/przesuniecie_pkg.sv
// Shared definitions for the arithmetic left-shift unit: default width and shift-code decode.
package przesuniecie_pkg;

  localparam int unsigned DEF_BITS = 32;
  localparam int unsigned SHW      = $clog2(DEF_BITS) + 1;

  typedef struct packed {
    logic           err;  // N negative
    logic           gt;   // N > BITS
    logic           eq;   // N == BITS
    logic [SHW-1:0] n;    // N, meaningful only when 0 <= N <= BITS
  } shift_dec_t;

  // Shift code is the complement of N; the caller zero-extends its operand to 64 bits.
  function automatic shift_dec_t decode_shift(input logic [63:0] b, input int unsigned bits);
    shift_dec_t  d;
    logic [63:0] mask;
    logic [63:0] n_val;
    mask  = {64{1'b1}} >> (64 - bits);
    n_val = ~b & mask;
    d.err = ~b[bits-1];
    d.gt  = ~d.err && (n_val > 64'(bits));
    d.eq  = ~d.err && (n_val == 64'(bits));
    d.n   = n_val[SHW-1:0];
    return d;
  endfunction

endpackage

// File: rtl/przesuniecie_barrel.sv
// Combinational log2(BITS)-stage left barrel shifter with lost-significant-bit detection.
// No latency, no flow control; an MSB set in n_i flushes the operand completely.
module przesuniecie_barrel
  import przesuniecie_pkg::*;
#(
  parameter int unsigned BITS = DEF_BITS
) (
  input  logic [BITS-1:0] a_i,
  input  logic [SHW-1:0]  n_i,
  output logic [BITS-1:0] shifted_o,
  output logic            lost_o
);

  logic [BITS-1:0] v;
  logic            lost;

  // Each stage loses bits iff its shift cannot be undone by an arithmetic right shift.
  always_comb begin
    v    = a_i;
    lost = 1'b0;
    for (int k = 0; k < int'(SHW) - 1; k++) begin
      if (n_i[k]) begin
        if (($signed(v << (1 << k)) >>> (1 << k)) != $signed(v)) lost = 1'b1;
        v = v << (1 << k);
      end
    end
    if (n_i[SHW-1]) begin
      v    = '0;
      lost = |a_i;
    end
  end

  assign shifted_o = v;
  assign lost_o    = lost;

endmodule

// File: rtl/przesuniecie_unit.sv
// Registered arithmetic left shift A <<< ~B with error and overflow flags.
// Latency 1 cycle, sampled every clock, no handshake or backpressure.
module przesuniecie_unit
  import przesuniecie_pkg::*;
#(
  parameter int unsigned BITS = DEF_BITS
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  output logic [BITS-1:0] o_result,
  output logic            o_error,
  output logic            o_overflow
);

  shift_dec_t      dec;
  logic [BITS-1:0] shifted;
  logic            lost;
  logic [BITS-1:0] result_d, result_q;
  logic            error_d, error_q;
  logic            overflow_d, overflow_q;

  assign dec = decode_shift(64'(i_arg_B), BITS);

  przesuniecie_barrel #(.BITS(BITS)) u_barrel (
    .a_i       (i_arg_A),
    .n_i       (dec.n),
    .shifted_o (shifted),
    .lost_o    (lost)
  );

  always_comb begin
    result_d   = '0;
    error_d    = 1'b0;
    overflow_d = 1'b0;
    if (dec.err) begin
      error_d = 1'b1;
    end else if (dec.gt) begin
      overflow_d = 1'b1;
    end else if (dec.eq) begin
      // Full-width shift: everything is lost unless A was already zero.
      overflow_d = |i_arg_A;
    end else begin
      result_d   = shifted;
      overflow_d = lost;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      result_q   <= '0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_result   = result_q;
  assign o_error    = error_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_przesuniecie_unit.sv
// Randomised and directed check of przesuniecie_unit against a behavioural shift model.
module tb_przesuniecie_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] arg_a;
  logic [31:0] arg_b;
  logic [31:0] result;
  logic        error;
  logic        overflow;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  przesuniecie_unit #(.BITS(32)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_arg_A    (arg_a),
    .i_arg_B    (arg_b),
    .o_result   (result),
    .o_error    (error),
    .o_overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: N = signed(~B); plain arithmetic on 64-bit ints.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic err, output logic ovf);
    longint n;
    longint sa;
    longint back;
    n   = longint'($signed(~b));
    sa  = longint'($signed(a));
    res = '0;
    err = 1'b0;
    ovf = 1'b0;
    if (n < 0) begin
      err = 1'b1;
    end else if (n > 32) begin
      ovf = 1'b1;
    end else begin
      res  = (n == 32) ? 32'h0 : a << n;
      back = longint'($signed(res)) / (longint'(1) << n);
      // Exact division only when no bits lost; otherwise compare via the fill rule.
      ovf  = (sa * (longint'(1) << n)) != longint'($signed(res));
      if (back == 0 && sa == 0) ovf = 1'b0;
    end
  endtask

  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_res;
    logic        e_err;
    logic        e_ovf;
    @(negedge clk);
    arg_a = a;
    arg_b = b;
    model(a, b, e_res, e_err, e_ovf);
    @(posedge clk);
    #1;
    chk({tag, ".res"}, result, e_res);
    chk({tag, ".err"}, 32'(error), 32'(e_err));
    chk({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] n;
    rst_n = 1'b0;
    arg_a = '0;
    arg_b = '0;
    #12;
    chk("rst.res", result, 32'h0);
    chk("rst.err", 32'(error), 32'h0);
    chk("rst.ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("shl5",     32'h0000_0003, ~32'd5);
    chk("shl5.lit", result, 32'h0000_0060);
    apply("n0",       32'h1234_5678, 32'hFFFF_FFFF);
    chk("n0.lit", result, 32'h1234_5678);
    apply("ovf1",     32'h4000_0000, ~32'd1);
    chk("ovf1.lit", 32'(overflow), 32'h1);
    apply("neg1",     32'hC000_0000, ~32'd1);
    chk("neg1.lit", {result[31:1], overflow}, 32'h8000_0000);
    apply("n32.zero", 32'h0000_0000, ~32'd32);
    apply("n32.min",  32'h8000_0000, ~32'd32);
    chk("n32.min.lit", 32'(overflow), 32'h1);
    apply("n32.one",  32'h0000_0001, ~32'd32);
    apply("err5",     32'hDEAD_BEEF, 32'h0000_0005);
    chk("err5.lit", 32'(error), 32'h1);

    // Asynchronous reset while outputs hold a nonzero result.
    apply("pre.rst",  32'h0000_00FF, ~32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.res", result, 32'h0);
    chk("arst.err", 32'(error), 32'h0);
    chk("arst.ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      n = 32'($urandom_range(32'h7FFF_FFFF, 33));
      case (i % 4)
        0:       a = 32'h0;
        1:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      apply("big", a, ~n);
    end
    for (int i = 0; i < 20; i++) apply("err", $urandom, {1'b0, 31'($urandom)});
    for (int i = 0; i < 400; i++) begin
      n = 32'($urandom_range(31, 0));
      case (i % 5)
        0:       a = {32{a[0]}} ^ (32'h1 << $urandom_range(31, 0));
        1:       a = 32'($signed(32'($urandom)) >>> $urandom_range(31, 0));
        default: a = $urandom;
      endcase
      apply("sweep", a, ~n);
    end
    for (int i = 0; i < 40; i++) apply("anyb", $urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
